// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg : shared FSM state encoding and default widths for seq_divider
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int DIVIDEND_W_DEFAULT = 36;
  localparam int DIVISOR_W_DEFAULT  = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step : one restoring-division step (shift in a bit, trial subtract, select)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_step #(
  parameter int DIVISOR_W = 18
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] trial;
  logic                 unused_trial_msb;

  assign shifted = {rem_in, bit_in};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};

  // A clear borrow bit means the shifted remainder was >= divisor.
  assign q_bit   = ~trial[DIVISOR_W+1];

  // After a successful subtract the result is below the divisor, so its top
  // bit is always zero; after a restore the top bit of shifted is zero too.
  assign rem_out = q_bit ? trial[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];

  assign unused_trial_msb = trial[DIVISOR_W];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider : unsigned radix-2 restoring divider, one quotient bit per cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEFAULT,
  parameter int DIVISOR_W  = DIVISOR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int                CNT_W    = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q,   dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q,   dvs_d;
  logic [DIVISOR_W-1:0]  rem_q,   rem_d;
  logic [DIVIDEND_W-1:0] quo_q,   quo_d;
  logic [DIVISOR_W-1:0]  rmd_q,   rmd_d;
  logic                  dbz_q,   dbz_d;

  logic                  step_q_bit;
  logic [DIVISOR_W-1:0]  step_rem;
  logic [DIVIDEND_W-1:0] dvd_shift;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom,
  // so after DIVIDEND_W steps this register holds the full quotient.
  assign dvd_shift = {dvd_q[DIVIDEND_W-2:0], step_q_bit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          dvs_d = divisor;
          if (divisor == '0) begin
            state_d = ST_DONE;
            quo_d   = '1;
            rmd_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            dvd_d   = dividend;
            rem_d   = '0;
          end
        end
      end

      ST_CALC: begin
        dvd_d = dvd_shift;
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          quo_d   = dvd_shift;
          rmd_d   = step_rem;
          dbz_d   = 1'b0;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
